// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding and image framing constants.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_byte_to_word_packer.sv
// Shifts accepted bytes into a little-endian 32-bit word; flags the byte that completes a word.
module byte_to_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_data,
    output logic        word_valid
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;

    // word_data already includes the incoming byte so the top can register it in the same cycle
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        word_valid = 1'b0;
        word_data  = {byte_in, acc_q[31:8]};
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (byte_en) begin
            acc_d      = word_data;
            cnt_d      = cnt_q + 2'd1;
            word_valid = (cnt_q == 2'(BYTES_PER_WORD - 1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checked byte image into instruction memory, then releases the core.
//  state | meaning
//  IDLE  | waiting for start after reset
//  HDR0  | expecting word-count low byte
//  HDR1  | expecting word-count high byte, length validated here
//  DATA  | packing data bytes, one imem write per 4 bytes
//  CHK   | expecting checksum byte
//  DONE  | image verified, core released
//  ERR   | bad length or checksum, core held in reset
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW        = ADDR_WIDTH + 1;
    localparam int MAX_WORDS = 2 ** ADDR_WIDTH;

    state_t         state_q, state_d;
    logic [7:0]     len_lo_q, len_lo_d;
    logic [CW-1:0]  len_q, len_d;
    logic [CW-1:0]  word_idx_q, word_idx_d;
    logic [7:0]     csum_q, csum_d;
    logic           s_ready_q, s_ready_d;
    logic           imem_we_q, imem_we_d;
    logic [31:0]    imem_addr_q, imem_addr_d;
    logic [31:0]    imem_wd_q, imem_wd_d;
    logic           core_rst_q, core_rst_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           accept;
    logic           pk_clr;
    logic           pk_word_valid;
    logic [31:0]    pk_word;
    logic [15:0]    hdr_n;

    assign accept = s_valid && s_ready_q;
    assign hdr_n  = {s_data, len_lo_q};

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (pk_clr),
        .byte_en    (accept && (state_q == ST_DATA)),
        .byte_in    (s_data),
        .word_data  (pk_word),
        .word_valid (pk_word_valid)
    );

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        csum_d      = csum_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_wd_d   = imem_wd_q;
        pk_clr      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_HDR0;
                    csum_d     = '0;
                    word_idx_d = '0;
                    pk_clr     = 1'b1;
                end
            end
            ST_HDR0: begin
                if (accept) begin
                    len_lo_d = s_data;
                    state_d  = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (accept) begin
                    if ((hdr_n == 16'd0) || ({16'd0, hdr_n} > 32'(MAX_WORDS))) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d   = hdr_n[CW-1:0];
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ s_data;
                    if (pk_word_valid) begin
                        imem_we_d   = 1'b1;
                        imem_addr_d = 32'({word_idx_q[ADDR_WIDTH-1:0], 2'b00});
                        imem_wd_d   = pk_word;
                        word_idx_d  = CW'(word_idx_q + 1'b1);
                        if (word_idx_d == len_q) begin
                            state_d = ST_CHK;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (accept) begin
                    state_d = (s_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // status outputs are registered copies of the next-state decode
        s_ready_d  = state_d inside {ST_HDR0, ST_HDR1, ST_DATA, ST_CHK};
        busy_d     = s_ready_d;
        done_d     = (state_d == ST_DONE);
        core_rst_d = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            word_idx_q  <= '0;
            csum_q      <= '0;
            s_ready_q   <= 1'b0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_wd_q   <= '0;
            core_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            csum_q      <= csum_d;
            s_ready_q   <= s_ready_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_wd_q   <= imem_wd_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign imem_we   = imem_we_q;
    assign imem_addr = imem_addr_q;
    assign imem_wd   = imem_wd_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench: expected imem writes go into a queue, a negedge monitor pops and compares them.
module tb_imem_boot_loader;

    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_w;
    logic [7:0]  img[$];

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // write monitor: every strobe must match the head of the expectation queue
    always @(negedge clk) begin
        if (rst && imem_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL imem_write: got addr=%h wd=%h, expected no write", imem_addr, imem_wd);
            end else begin
                exp_w = exp_q.pop_front();
                if ({imem_addr, imem_wd} !== exp_w) begin
                    n_fail++;
                    $display("FAIL imem_write: got addr=%h wd=%h, expected addr=%h wd=%h",
                             imem_addr, imem_wd, exp_w[63:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input logic e_busy, input logic e_done,
                                input logic e_err, input logic e_core);
        check({name, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
        check({name, "_ready"}, {31'd0, s_ready}, {31'd0, e_busy});
        check({name, "_done"}, {31'd0, done}, {31'd0, e_done});
        check({name, "_err"}, {31'd0, err}, {31'd0, e_err});
        check({name, "_core_rst"}, {31'd0, core_rst}, {31'd0, e_core});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_ready);
        int budget;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        if (chk_ready) check("ready_in_data", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data  = b;
        budget  = 0;
        while (!s_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, budget);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_image(input int gap_max, input bit chk_ready);
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0,
                      chk_ready && (i > 2) && (i < img.size() - 1));
        end
    endtask

    task automatic load_basic_image(input logic [7:0] csum);
        img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00};
        img.push_back(csum);
        exp_q.push_back({32'h0000_0000, 32'h0050_0093});
        exp_q.push_back({32'h0000_0004, 32'h0030_0113});
    endtask

    task automatic settle_and_check_queue(input string name);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #8;
        check("reset_we", {31'd0, imem_we}, 32'd0);
        check("reset_addr", imem_addr, 32'd0);
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        #4 rst = 1'b1;
        @(posedge clk); #1;

        // good image
        pulse_start();
        check_status("hdr0", 1'b1, 1'b0, 1'b0, 1'b0);
        load_basic_image(8'hE1);
        send_image(0, 1'b0);
        check_status("good_done", 1'b0, 1'b1, 1'b0, 1'b1);
        check("good_addr_hold", imem_addr, 32'h0000_0004);
        check("good_wd_hold", imem_wd, 32'h0030_0113);
        settle_and_check_queue("good_queue");

        // restart from DONE, bad checksum
        pulse_start();
        check_status("restart", 1'b1, 1'b0, 1'b0, 1'b0);
        load_basic_image(8'hE0);
        send_image(0, 1'b0);
        check_status("bad_csum", 1'b0, 1'b0, 1'b1, 1'b0);
        settle_and_check_queue("bad_csum_queue");

        // length boundaries with ADDR_WIDTH=4
        pulse_start();
        img = '{8'h00, 8'h00};
        send_image(0, 1'b0);
        check_status("len_zero", 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start();
        img = '{8'h11, 8'h00};
        send_image(0, 1'b0);
        check_status("len_17", 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start();
        img = '{8'h10, 8'h00};
        for (int w = 0; w < 16; w++) begin
            repeat (4) img.push_back(8'(w));
            exp_q.push_back({32'(w * 4), {4{8'(w)}}});
        end
        img.push_back(8'h00);
        send_image(0, 1'b0);
        check_status("len_16", 1'b0, 1'b1, 1'b0, 1'b1);
        settle_and_check_queue("len_16_queue");

        // random gaps on the good image
        pulse_start();
        load_basic_image(8'hE1);
        send_image(3, 1'b1);
        check_status("gaps_done", 1'b0, 1'b1, 1'b0, 1'b1);
        settle_and_check_queue("gaps_queue");

        // async reset from DONE
        #3 rst = 1'b0;
        #2;
        check("async_we", {31'd0, imem_we}, 32'd0);
        check("async_addr", imem_addr, 32'd0);
        check("async_wd", imem_wd, 32'd0);
        check_status("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        #4 rst = 1'b1;
        @(posedge clk); #1;

        // reset mid-load, then full reload with a stray start while busy
        pulse_start();
        exp_q.push_back({32'h0000_0000, 32'h0050_0093});
        img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
        send_image(0, 1'b0);
        #3 rst = 1'b0;
        #2;
        check_status("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        #4 rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_queue", exp_q.size(), 32'd0);
        pulse_start();
        load_basic_image(8'hE1);
        for (int i = 0; i < 6; i++) send_byte(img[i], 0, 1'b0);
        pulse_start();
        check_status("busy_start", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 6; i < img.size(); i++) send_byte(img[i], 0, 1'b0);
        check_status("reload_done", 1'b0, 1'b1, 1'b0, 1'b1);
        settle_and_check_queue("reload_queue");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
